// File: rtl/alu_seq_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_seq_ctrl_if : handshake and strobe bundle between the control unit   |
// |                   and the ALU micro-sequencer                            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface alu_seq_ctrl_if;
  logic       start;
  logic [2:0] op_class;
  logic       abort;
  logic       mem_ack;
  logic [3:0] alu_in_sel;
  logic       mem_req;
  logic       mem_we;
  logic       reg_we;
  logic       pc_we;
  logic       sp_dec;
  logic       sp_inc;
  logic       busy;
  logic       done;
  logic       err;

  modport master (
    output start, op_class, abort, mem_ack,
    input  alu_in_sel, mem_req, mem_we, reg_we, pc_we, sp_dec, sp_inc, busy, done, err
  );

  modport slave (
    input  start, op_class, abort, mem_ack,
    output alu_in_sel, mem_req, mem_we, reg_we, pc_we, sp_dec, sp_inc, busy, done, err
  );
endinterface
`default_nettype wire

// File: rtl/alu_seq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_seq_ctrl : multi-cycle EXEC/MEM/WB micro-sequencer with Moore outputs |
// | Optional memory-wait watchdog enabled by defining ALU_SEQ_TIMEOUT_EN.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module alu_seq_ctrl #(
  parameter logic [7:0] TIMEOUT_CYCLES = 8'd255
) (
  input logic          clk,
  input logic          rst,
  alu_seq_ctrl_if.slave bus
);

  localparam logic [2:0] c_idle  = 3'd0;
  localparam logic [2:0] c_exec  = 3'd1;
  localparam logic [2:0] c_mem_a = 3'd2;
  localparam logic [2:0] c_mem_b = 3'd3;
  localparam logic [2:0] c_wb    = 3'd4;
  localparam logic [2:0] c_trap  = 3'd5;

  localparam logic [2:0] c_cls_alu    = 3'b000;
  localparam logic [2:0] c_cls_unary  = 3'b001;
  localparam logic [2:0] c_cls_branch = 3'b010;
  localparam logic [2:0] c_cls_load   = 3'b011;
  localparam logic [2:0] c_cls_push   = 3'b100;
  localparam logic [2:0] c_cls_pop    = 3'b101;
  localparam logic [2:0] c_cls_cmem   = 3'b110;
  localparam logic [2:0] c_cls_ill    = 3'b111;

  logic [2:0] r_state;
  logic [2:0] w_next;
  logic [2:0] r_class;
  logic       w_accept;
  logic       w_timeout;

  logic [3:0] w_sel;
  logic       w_mem_req, w_mem_we, w_reg_we, w_pc_we, w_sp_dec, w_sp_inc;
  logic       w_busy, w_done, w_err;

  assign w_accept = (r_state == c_idle) && bus.start && !bus.abort;

`ifdef ALU_SEQ_TIMEOUT_EN
  logic [7:0] r_wait_cnt;
  logic       w_in_mem;

  assign w_in_mem  = (r_state == c_mem_a) || (r_state == c_mem_b);
  assign w_timeout = w_in_mem && !bus.mem_ack && (r_wait_cnt == TIMEOUT_CYCLES - 8'd1);

  // Any state change clears the count, so each MEM state starts from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait_cnt <= 8'd0;
    end else if (w_next != r_state) begin
      r_wait_cnt <= 8'd0;
    end else if (w_in_mem && !bus.mem_ack) begin
      r_wait_cnt <= r_wait_cnt + 8'd1;
    end
  end
`else
  logic w_unused_timeout;
  assign w_timeout        = 1'b0;
  assign w_unused_timeout = ^TIMEOUT_CYCLES;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_idle;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_class <= 3'b000;
    end else if (w_accept) begin
      r_class <= bus.op_class;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_idle: begin
        if (bus.start) begin
          case (bus.op_class)
            c_cls_ill:              w_next = c_trap;
            c_cls_load, c_cls_cmem: w_next = c_mem_a;
            default:                w_next = c_exec;
          endcase
        end
      end
      c_exec: begin
        if (r_class == c_cls_push || r_class == c_cls_pop) w_next = c_mem_a;
        else                                               w_next = c_wb;
      end
      c_mem_a: begin
        if (bus.mem_ack)    w_next = (r_class == c_cls_cmem) ? c_mem_b : c_wb;
        else if (w_timeout) w_next = c_trap;
      end
      c_mem_b: begin
        if (bus.mem_ack)    w_next = c_wb;
        else if (w_timeout) w_next = c_trap;
      end
      c_wb, c_trap: w_next = c_idle;
      default:      w_next = c_idle;
    endcase
    // Flush wins over every other transition, including the accept in IDLE.
    if (bus.abort) w_next = c_idle;
  end

  always_comb begin
    w_sel     = 4'b1111;
    w_mem_req = 1'b0;
    w_mem_we  = 1'b0;
    w_reg_we  = 1'b0;
    w_pc_we   = 1'b0;
    w_sp_dec  = 1'b0;
    w_sp_inc  = 1'b0;
    w_busy    = (r_state != c_idle);
    w_done    = 1'b0;
    w_err     = 1'b0;
    case (r_state)
      c_exec: begin
        case (r_class)
          c_cls_alu:    w_sel = 4'b0000;
          c_cls_unary:  w_sel = 4'b0001;
          c_cls_branch: w_sel = 4'b0011;
          c_cls_push:   w_sel = 4'b0110;
          c_cls_pop:    w_sel = 4'b0111;
          default:      w_sel = 4'b1111;
        endcase
      end
      c_mem_a: begin
        w_mem_req = 1'b1;
        w_mem_we  = (r_class == c_cls_push);
        case (r_class)
          c_cls_load: w_sel = 4'b0101;
          c_cls_push: w_sel = 4'b0110;
          c_cls_pop:  w_sel = 4'b0111;
          c_cls_cmem: w_sel = 4'b1001;
          default:    w_sel = 4'b1111;
        endcase
      end
      c_mem_b: begin
        w_mem_req = 1'b1;
        w_sel     = 4'b1010;
      end
      c_wb: begin
        w_done = 1'b1;
        case (r_class)
          c_cls_alu:    begin w_sel = 4'b0000; w_reg_we = 1'b1; end
          c_cls_unary:  begin w_sel = 4'b0001; w_reg_we = 1'b1; end
          c_cls_branch: begin w_sel = 4'b0011; w_pc_we  = 1'b1; end
          c_cls_load:   begin w_sel = 4'b0101; w_reg_we = 1'b1; end
          c_cls_push:   begin w_sel = 4'b0110; w_sp_dec = 1'b1; end
          // POP writes back the popped word through the load path
          c_cls_pop:    begin w_sel = 4'b0101; w_reg_we = 1'b1; w_sp_inc = 1'b1; end
          c_cls_cmem:   begin w_sel = 4'b1010; w_reg_we = 1'b1; end
          default:      w_sel = 4'b1111;
        endcase
      end
      c_trap: begin
        w_done = 1'b1;
        w_err  = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.alu_in_sel = w_sel;
  assign bus.mem_req    = w_mem_req;
  assign bus.mem_we     = w_mem_we;
  assign bus.reg_we     = w_reg_we;
  assign bus.pc_we      = w_pc_we;
  assign bus.sp_dec     = w_sp_dec;
  assign bus.sp_inc     = w_sp_inc;
  assign bus.busy       = w_busy;
  assign bus.done       = w_done;
  assign bus.err        = w_err;

endmodule
`default_nettype wire
